// File: rtl/xgriscv_ifetch_pkg.sv
// ----------------------------------------------------------------------------
// xgriscv_ifetch_pkg
//   Shared constants and types for the xgriscv instruction-fetch stage.
//   - ADDR_SIZE / INSTR_SIZE : address and instruction widths (32)
//   - INSTR_NOP              : canonical NOP (addi x0,x0,0) shown in empty slots
//   - if_state_e             : fetch FSM states (2-bit encoding)
//   - ifid_t                 : IF/ID pipeline register payload
//   - pc_align()             : clears the two low address bits
// ----------------------------------------------------------------------------
package xgriscv_ifetch_pkg;

   localparam int unsigned ADDR_SIZE  = 32;
   localparam int unsigned INSTR_SIZE = 32;

   localparam logic [INSTR_SIZE-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_REQ   = 2'd0,  // request driven, waiting for grant
      IF_WAIT  = 2'd1,  // granted, waiting for response
      IF_DRAIN = 2'd2,  // discarding one stale response after a redirect
      IF_SKID  = 2'd3   // response parked in skid buffer while decode stalls
   } if_state_e;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_SIZE-1:0]  pc;
      logic [ADDR_SIZE-1:0]  pcplus4;
      logic [INSTR_SIZE-1:0] instr;
   } ifid_t;

   function automatic logic [ADDR_SIZE-1:0] pc_align(input logic [ADDR_SIZE-1:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/xgriscv_ifetch_if.sv
// ----------------------------------------------------------------------------
// xgriscv_ifetch_if
//   Bundles the fetch stage's instruction-memory handshake, the decode-side
//   control (stall / redirect) and the IF/ID outputs.
//   master : the fetch stage (drives imem_req/addr and id_*)
//   slave  : the environment (instruction memory + decode stage)
//   Signals:
//     stall_id, redirect, redirect_pc       decode -> fetch
//     imem_req, imem_addr                   fetch  -> memory
//     imem_gnt, imem_rvalid, imem_rdata     memory -> fetch
//     id_valid, id_pc, id_pcplus4, id_instr fetch  -> decode
// ----------------------------------------------------------------------------
interface xgriscv_ifetch_if;
   import xgriscv_ifetch_pkg::*;

   logic                  stall_id;
   logic                  redirect;
   logic [ADDR_SIZE-1:0]  redirect_pc;

   logic                  imem_req;
   logic [ADDR_SIZE-1:0]  imem_addr;
   logic                  imem_gnt;
   logic                  imem_rvalid;
   logic [INSTR_SIZE-1:0] imem_rdata;

   logic                  id_valid;
   logic [ADDR_SIZE-1:0]  id_pc;
   logic [ADDR_SIZE-1:0]  id_pcplus4;
   logic [INSTR_SIZE-1:0] id_instr;

   modport master (
      input  stall_id, redirect, redirect_pc,
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output id_valid, id_pc, id_pcplus4, id_instr
   );

   modport slave (
      output stall_id, redirect, redirect_pc,
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  id_valid, id_pc, id_pcplus4, id_instr
   );

endinterface

// File: rtl/xgriscv_ifetch_ifid_reg.sv
// ----------------------------------------------------------------------------
// xgriscv_ifid_reg
//   IF/ID pipeline register holding {valid, pc, pcplus4, instr}.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     i_ld       : load i_d
//     i_flush    : clear valid and show NOP (wins over i_ld)
//     i_d        : next payload
//     o_q        : current payload
//   Reset clears pc/pcplus4 to 0; flush leaves them untouched.
// ----------------------------------------------------------------------------
module xgriscv_ifid_reg
   import xgriscv_ifetch_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  i_ld,
   input  logic  i_flush,
   input  ifid_t i_d,
   output ifid_t o_q
);

   ifid_t r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q.valid   <= 1'b0;
         r_q.pc      <= '0;
         r_q.pcplus4 <= '0;
         r_q.instr   <= INSTR_NOP;
      end else if (i_flush) begin
         r_q.valid   <= 1'b0;
         r_q.instr   <= INSTR_NOP;
      end else if (i_ld) begin
         r_q         <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/xgriscv_ifetch.sv
// ----------------------------------------------------------------------------
// xgriscv_ifetch
//   Instruction-fetch stage: holds the PC, issues one instruction-memory
//   request at a time (req/gnt/rvalid) and feeds decode through the IF/ID
//   register, with stall, redirect/flush and a one-entry skid buffer.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     bus        : xgriscv_ifetch_if.master (memory handshake, decode control,
//                  IF/ID outputs)
//   Parameter:
//     RESET_PC   : PC loaded on reset
// ----------------------------------------------------------------------------
module xgriscv_ifetch
   import xgriscv_ifetch_pkg::*;
#(
   parameter logic [ADDR_SIZE-1:0] RESET_PC = 32'h0000_0000
)(
   input  logic               clk,
   input  logic               reset,
   xgriscv_ifetch_if.master   bus
);

   if_state_e             r_state;
   if_state_e             w_state_nxt;
   logic [ADDR_SIZE-1:0]  r_pc;
   logic [ADDR_SIZE-1:0]  r_skid_pc;
   logic [INSTR_SIZE-1:0] r_skid_instr;

   logic [ADDR_SIZE-1:0]  w_pc_plus4;
   logic                  w_ld;
   logic                  w_resp;
   logic                  w_ifid_ld;
   logic                  w_ifid_flush;
   ifid_t                 w_ifid_d;
   ifid_t                 w_ifid_q;

   assign w_pc_plus4 = r_pc + 32'd4;
   // IF/ID may take new data when decode consumes or the slot is empty
   assign w_ld       = !bus.stall_id || !w_ifid_q.valid;
   assign w_resp     = (r_state == IF_WAIT) && bus.imem_rvalid;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IF_REQ;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      if (bus.redirect) begin
         // drain only if a request is still outstanding after this edge
         unique case (r_state)
            IF_REQ:   w_state_nxt = bus.imem_gnt    ? IF_DRAIN : IF_REQ;
            IF_WAIT:  w_state_nxt = bus.imem_rvalid ? IF_REQ   : IF_DRAIN;
            IF_DRAIN: w_state_nxt = bus.imem_rvalid ? IF_REQ   : IF_DRAIN;
            IF_SKID:  w_state_nxt = IF_REQ;
            default:  w_state_nxt = IF_REQ;
         endcase
      end else begin
         unique case (r_state)
            IF_REQ:   if (bus.imem_gnt)    w_state_nxt = IF_WAIT;
            IF_WAIT:  if (bus.imem_rvalid) w_state_nxt = w_ld ? IF_REQ : IF_SKID;
            IF_DRAIN: if (bus.imem_rvalid) w_state_nxt = IF_REQ;
            IF_SKID:  if (!bus.stall_id)   w_state_nxt = IF_REQ;
            default:  w_state_nxt = IF_REQ;
         endcase
      end
   end

   // ---------------- output / datapath control ----------------
   always_comb begin
      bus.imem_req  = (r_state == IF_REQ) && !reset;
      bus.imem_addr = r_pc;

      w_ifid_flush  = 1'b0;
      w_ifid_ld     = 1'b0;
      w_ifid_d      = '{valid: 1'b1, pc: r_pc, pcplus4: w_pc_plus4,
                        instr: bus.imem_rdata};

      if (bus.redirect) begin
         // flush overrides stall_id
         w_ifid_flush = 1'b1;
      end else if (r_state == IF_WAIT) begin
         if (bus.imem_rvalid) begin
            w_ifid_ld = w_ld;
         end else if (w_ld) begin
            w_ifid_flush = 1'b1;  // decode consumed the slot, nothing new yet
         end
      end else if (r_state == IF_SKID && !bus.stall_id) begin
         w_ifid_ld = 1'b1;
         w_ifid_d  = '{valid: 1'b1, pc: r_skid_pc,
                       pcplus4: r_skid_pc + 32'd4, instr: r_skid_instr};
      end
   end

   // ---------------- PC and skid buffer ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_skid_pc    <= '0;
         r_skid_instr <= INSTR_NOP;
      end else if (bus.redirect) begin
         r_pc         <= pc_align(bus.redirect_pc);
         r_skid_pc    <= '0;
         r_skid_instr <= INSTR_NOP;
      end else if (w_resp) begin
         r_pc <= w_pc_plus4;
         if (!w_ld) begin
            r_skid_pc    <= r_pc;
            r_skid_instr <= bus.imem_rdata;
         end
      end
   end

   xgriscv_ifid_reg u_ifid (
      .clk     (clk),
      .reset   (reset),
      .i_ld    (w_ifid_ld),
      .i_flush (w_ifid_flush),
      .i_d     (w_ifid_d),
      .o_q     (w_ifid_q)
   );

   assign bus.id_valid   = w_ifid_q.valid;
   assign bus.id_pc      = w_ifid_q.pc;
   assign bus.id_pcplus4 = w_ifid_q.pcplus4;
   assign bus.id_instr   = w_ifid_q.instr;

endmodule

// File: doc/xgriscv_ifetch.md
# xgriscv_ifetch

Instruction-fetch stage of the xgriscv pipeline, directly upstream of the decode stage and its controller. It holds the PC and issues one instruction-memory request at a time over a request/grant/response handshake. It delivers fetched instructions to the decode stage through the IF/ID pipeline register, with stall, flush/redirect and a one-entry skid buffer. Flushed or empty slots present the canonical NOP, so decode always sees a legal instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- stall_id  in  1  decode cannot accept; IF/ID must hold
- redirect  in  1  taken branch, jal or jalr resolved in decode
- redirect_pc  in  32  target address; bits [1:0] forced to 0 internally
- imem_req  out  1  request valid
- imem_addr  out  32  request address (= pc_q)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- id_valid  out  1  IF/ID holds a live instruction
- id_pc  out  32  PC of id_instr
- id_pcplus4  out  32  id_pc + 4
- id_instr  out  32  instruction to decode

## Operation
- State machine states:
  - REQ: imem_req=1, imem_addr=pc_q. On imem_gnt go to WAIT.
  - WAIT: imem_req=0, awaiting imem_rvalid.
  - DRAIN: imem_req=0, discarding one stale response.
  - SKID: imem_req=0, skid buffer full.
- IF/ID load enable: ld = !stall_id || !id_valid.
- WAIT with imem_rvalid:
  - If ld: IF/ID <= {1, pc_q, pc_q+4, imem_rdata}, pc_q <= pc_q+4, go to REQ.
  - Else: skid <= {pc_q, imem_rdata}, pc_q <= pc_q+4, go to SKID.
- WAIT with ld and no response: id_valid <= 0 and id_instr <= NOP (consumed bubble).
- SKID with !stall_id: IF/ID <= skid, go to REQ.
- Redirect has priority over all other events in the same cycle:
  - pc_q <= {redirect_pc[31:2],2'b00}
  - id_valid <= 0, id_instr <= NOP (32'h0000_0013), skid cleared; stall_id is ignored for this flush.
  - Next state is DRAIN if a request is outstanding after this edge: state WAIT without rvalid, or state REQ with imem_gnt.
  - Next state is REQ otherwise: state REQ without gnt, state WAIT with rvalid (that response is discarded), or state SKID.
- DRAIN: on imem_rvalid discard the data and go to REQ. A redirect during DRAIN updates pc_q and stays in DRAIN.
- imem_rvalid in REQ or SKID is a protocol violation and is ignored. Only one request is outstanding at a time.
- All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Values held during reset:
  - state = REQ, pc_q = RESET_PC
  - imem_req = 0 (forced while reset high), imem_addr = RESET_PC
  - id_valid = 0, id_pc = 0, id_pcplus4 = 0, id_instr = 32'h0000_0013
- imem_req rises in the first cycle after reset deasserts.
- Best case, with gnt in the request cycle and rvalid the next cycle:
  - request in cycle 0, response in cycle 1, id_valid in cycle 2.
  - Throughput is one instruction per 2 cycles.
- Redirect in cycle t: id_valid = 0 from t+1. The earliest request to redirect_pc is in t+1 (from REQ) or in the cycle after the stale response (from DRAIN).
- Reset asserted mid-transaction abandons any outstanding response. Memory must drop it on reset, since reset is shared.
- imem_addr is stable while imem_req=1 and no gnt, except when changed by a redirect.

## Structure
- Constants added to xgriscv_defines.v:
  - IF state encodings (2-bit)
  - `INSTR_NOP 32'h0000_0013
  - `ADDR_SIZE / `INSTR_SIZE (32)
- One sub-module is natural: xgriscv_ifid_reg, the IF/ID register holding {valid, pc, pcplus4, instr} with load and flush inputs. The flush value is NOP and valid=0.
- FSM, pc_q and skid live in xgriscv_ifetch.

## Test plan
- Reset release, memory with gnt in the request cycle and rvalid one cycle later returning 32'h0050_0093 → imem_addr=0 in cycle 0, id_valid=1 in cycle 2 with id_pc=0, id_pcplus4=4, id_instr=32'h0050_0093; next imem_addr=4.
- stall_id held high while the second response (pc 4) arrives → state SKID, id_pc stays 0. Release stall → id_pc=4 next cycle, then request to 8.
- Redirect to 32'h0000_0102 while in WAIT → id_valid=0 and id_instr=NOP next cycle; the stale response is discarded; the next request has imem_addr=32'h0000_0100.
- Redirect and stall_id together while id_valid=1 → the flush wins and id_valid=0.
- Redirect in REQ with gnt in the same cycle → DRAIN; the old response never reaches IF/ID.
- Reset asserted in WAIT → all outputs at their reset values the next cycle; pc_q=RESET_PC.
